mul_add_seq: RTL and testbench

//   Sequential shift-add multiply-accumulate for the RSA datapath: P = Q*N + R.
//   It is the inverse of the divide/reduce stage: it rebuilds a dividend from

---
 rtl/rsa_pkg.sv | 15 +
 rtl/mul_add_seq.sv | 120 ++++++++++++
 tb/tb_mul_add_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
//   Types shared by the RSA datapath blocks.
//   mul_state_e : control states of the sequential multiply-accumulate
//                 (IDLE accepts operands, RUN iterates, DONE holds result).
// ---------------------------------------------------------------------------
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_add_seq.sv
// ---------------------------------------------------------------------------
// mul_add_seq
//   Sequential shift-add multiply-accumulate, P = Q*N + R.
//   Rebuilds a dividend from quotient/divisor/remainder and serves the product
//   steps of modular exponentiation. One multiplier bit per cycle, always
//   WIDTH iterations regardless of operand values (constant time).
//
// Ports
//   clk_i        in   1        clock, rising edge
//   rst_ni       in   1        asynchronous reset, active low
//   in_valid_i   in   1        q_i/n_i/r_i valid
//   in_ready_o   out  1        operands can be accepted (IDLE)
//   q_i          in   WIDTH    multiplier (quotient)
//   n_i          in   WIDTH    multiplicand (divisor/modulus)
//   r_i          in   WIDTH    addend (remainder)
//   out_valid_o  out  1        p_o holds the final result (DONE)
//   out_ready_i  in   1        consumer accepts p_o
//   p_o          out  2*WIDTH  Q*N+R while out_valid_o, else 0
//   busy_o       out  1        operation in flight (RUN or DONE)
// ---------------------------------------------------------------------------
module mul_add_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   q_i,
  input  logic [WIDTH-1:0]   n_i,
  input  logic [WIDTH-1:0]   r_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2*WIDTH-1:0] p_o,
  output logic               busy_o
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_e         state_q,  state_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        // Handshake inputs are only looked at here, so X on in_valid_i in
        // RUN/DONE cannot disturb the datapath.
        if (in_valid_i) begin
          acc_d    = {{WIDTH{1'b0}}, r_i};
          mcand_d  = {{WIDTH{1'b0}}, n_i};
          mplier_d = q_i;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        // Max result is 2^(2W)-2^W, so the 2W-bit sum never carries out.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Fixed WIDTH iterations; the counter is parked at 0 rather than
        // allowed to wrap so non-power-of-two widths behave identically.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // A coincident in_valid_i is deliberately not taken here; the new
        // operands are accepted from IDLE on the following edge.
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign p_o         = out_valid_o ? acc_q : '0;

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] q, n, r;
  logic [63:0] p;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  q8, n8, r8;
  logic [15:0] p8;

  int total;
  int passed;

  mul_add_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .q_i(q), .n_i(n), .r_i(r),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .p_o(p), .busy_o(busy)
  );

  mul_add_seq #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .q_i(q8), .n_i(n8), .r_i(r8),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .p_o(p8), .busy_o(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] n;
    logic [31:0] r;
    logic [63:0] p;
  } vec_t;

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  n;
    logic [7:0]  r;
    logic [15:0] p;
  } vec8_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Present operands on a falling edge; they are taken on the next rising edge.
  task automatic start32(input logic [31:0] qv, input logic [31:0] nv, input logic [31:0] rv);
    @(negedge clk);
    q = qv; n = nv; r = rv; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q = $urandom; n = $urandom; r = $urandom;
  endtask

  // Counts rising edges after the accepting edge until out_valid is seen.
  task automatic wait32(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain32(output logic [63:0] pv);
    pv = p;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run8(input vec8_t v, input string nm);
    int lat;
    @(negedge clk);
    q8 = v.q; n8 = v.n; r8 = v.r; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    q8 = 8'hA5; n8 = 8'h5A; r8 = 8'h3C;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk({nm, "_p"}, 64'(p8), 64'(v.p));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    vec_t        tbl[8];
    vec8_t       tbl8[4];
    int          lat;
    logic [63:0] pv;
    logic [31:0] a, dv;
    bit          seen;

    total = 0;
    passed = 0;

    tbl[0] = '{32'd3,         32'd5,         32'd2,         64'd17};
    tbl[1] = '{32'd0,         32'd9,         32'd4,         64'd4};
    tbl[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF_00000000};
    tbl[3] = '{32'd14,        32'd7,         32'd2,         64'd100};
    tbl[4] = '{32'd6,         32'd7,         32'd0,         64'd42};
    tbl[5] = '{32'd1,         32'hFFFFFFFF,  32'd0,         64'h00000000_FFFFFFFF};
    tbl[6] = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  64'h00000001_FFFFFFFE};
    tbl[7] = '{32'd12345,     32'd1000,      32'd678,       64'h0000000000BC614E};

    tbl8[0] = '{8'd3,   8'd5,   8'd2,   16'd17};
    tbl8[1] = '{8'hFF,  8'hFF,  8'hFF,  16'hFF00};
    tbl8[2] = '{8'd0,   8'd9,   8'd4,   16'd4};
    tbl8[3] = '{8'd200, 8'd100, 8'd50,  16'd20050};

    // Reset held with random inputs on both instances.
    rst_n = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    q = $urandom; n = $urandom; r = $urandom;
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    q8 = 8'($urandom); n8 = 8'($urandom); r8 = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_p",         p,              64'd0);
    chk("rst8_in_ready", 64'(in_ready8), 64'd1);
    chk("rst8_p",        64'(p8),        64'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0;
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
      start32(tbl[i].q, tbl[i].n, tbl[i].r);
      wait32(lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd32);
      drain32(pv);
      chk($sformatf("vec%0d_p", i), pv, tbl[i].p);
    end

    // Round trip through a divide: a = (a/n)*n + a%n.
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      dv = $urandom_range(1, (i % 2 == 0) ? 32'hFFFFFFFF : 32'd1000);
      start32(a / dv, dv, a % dv);
      wait32(lat);
      drain32(pv);
      chk($sformatf("rt%0d a=%0h n=%0h", i, a, dv), pv, {32'd0, a});
    end

    // Backpressure in DONE with in_valid pulses that must be ignored.
    start32(32'd3, 32'd5, 32'd2);
    wait32(lat);
    chk("bp_lat", 64'(lat), 64'd32);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      q = $urandom; n = $urandom; r = $urandom;
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_p", i),        p,                64'd17);
      chk($sformatf("bp%0d_valid", i),    64'(out_valid),   64'd1);
      chk($sformatf("bp%0d_in_ready", i), 64'(in_ready),    64'd0);
    end
    // Output handshake together with new operands: only the output is taken.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    q = 32'd2; n = 32'd3; r = 32'd1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_rel_in_ready", 64'(in_ready),  64'd1);
    chk("bp_rel_valid",    64'(out_valid), 64'd0);
    chk("bp_rel_p",        p,              64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_busy", 64'(busy), 64'd1);
    wait32(lat);
    chk("bp_next_lat", 64'(lat), 64'd32);
    drain32(pv);
    chk("bp_next_p", pv, 64'd7);

    // Reset in the middle of RUN.
    start32(32'hFFFF, 32'hFFFF, 32'd0);
    repeat (16) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_valid",    64'(out_valid), 64'd0);
    chk("mid_rst_busy",     64'(busy),      64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);
    start32(32'd6, 32'd7, 32'd0);
    wait32(lat);
    chk("post_rst_lat", 64'(lat), 64'd32);
    drain32(pv);
    chk("post_rst_p", pv, 64'd42);

    // WIDTH=8 regression.
    for (int i = 0; i < 4; i++) begin
      run8(tbl8[i], $sformatf("w8_vec%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
